// File: rtl/axis_decimator_ctrl_if.sv
// AXI-Stream style bundle used for both the ADC sample input and the
// decimated result output of axis_decimator_ctrl.
//
// Signals:
//   tdata  : packed payload, two lanes of TDATA_W/2 bits
//   tvalid : payload strobe from the master
//   tready : acceptance from the slave
//
// Modports:
//   master : drives tdata/tvalid, observes tready
//   slave  : observes tdata/tvalid, drives tready
interface axis_decimator_ctrl_if #(
    parameter int TDATA_W = 32
);
    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_decimator_ctrl.sv
// Acquisition sequencer for the dual-channel ADC decimation path.
//
// A start pulse arms an acquisition. Each window accumulates 2^k valid
// samples per channel and produces their floor-rounded average as one
// packed word on the output stream. The block stops after a programmed
// number of delivered results (0 = run forever) or on a stop pulse, and
// flags any window result that had to be dropped because the previous
// result was still waiting for the downstream sink.
//
// Ports:
//   aclk, aresetn   : clock, asynchronous active-low reset
//   s_axis_signal   : ADC samples, ch0 in [13:0], ch1 in [29:16]; never stalled
//   cfg_log2_dec    : decimation exponent k (clamped to MAX_LOG2_DEC)
//   cfg_num_blocks  : results to deliver before stopping, 0 = continuous
//   cfg_start       : one-cycle start pulse (only honoured when idle)
//   cfg_stop        : one-cycle stop pulse (wins over start)
//   m_axis_s01      : averaged result, ch1 in [31:16], ch0 in [15:0]
//   busy            : acquisition running or a result still pending
//   overrun         : sticky, a completed window was discarded
//   block_count     : results accepted downstream since the last start
module axis_decimator_ctrl #(
    parameter int AXIS_SIGNAL_TDATA_WIDTH            = 32,
    parameter int AXIS_SIGNAL_DATA_WIDTH             = 16,
    parameter int AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH = 14,
    parameter int MAX_LOG2_DEC                       = 8
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    axis_decimator_ctrl_if.slave         s_axis_signal,
    input  logic [3:0]                   cfg_log2_dec,
    input  logic [31:0]                  cfg_num_blocks,
    input  logic                         cfg_start,
    input  logic                         cfg_stop,
    axis_decimator_ctrl_if.master        m_axis_s01,
    output logic                         busy,
    output logic                         overrun,
    output logic [31:0]                  block_count
);
    localparam int SIG_W  = AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH;
    localparam int LANE_W = AXIS_SIGNAL_DATA_WIDTH;
    localparam int ACC_W  = SIG_W + MAX_LOG2_DEC;
    localparam int CNT_W  = MAX_LOG2_DEC + 1;
    localparam int PAD_W  = AXIS_SIGNAL_TDATA_WIDTH - 2 * SIG_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                              state;
    logic [3:0]                          k_r;
    logic [31:0]                         num_r;
    logic signed [ACC_W-1:0]             acc0;
    logic signed [ACC_W-1:0]             acc1;
    logic [CNT_W-1:0]                    cnt;
    logic [AXIS_SIGNAL_TDATA_WIDTH-1:0]  out_data;
    logic                                out_valid;

    // Exponents beyond what the accumulator can hold are clamped.
    function automatic logic [3:0] clamp_k(input logic [3:0] k);
        if (int'(k) > MAX_LOG2_DEC) return 4'(MAX_LOG2_DEC);
        return k;
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic [SIG_W-1:0] lane);
        return {{(ACC_W - SIG_W){lane[SIG_W-1]}}, lane};
    endfunction

    // Arithmetic shift gives floor rounding; the quotient of 2^k 14-bit
    // samples divided by 2^k always fits a 16-bit lane.
    function automatic logic [LANE_W-1:0] scale(input logic signed [ACC_W-1:0] sum,
                                                 input logic [3:0] k);
        return LANE_W'(sum >>> k);
    endfunction

    logic signed [ACC_W-1:0] sum0;
    logic signed [ACC_W-1:0] sum1;
    logic [CNT_W-1:0]        win_last_idx;
    logic                    xfer;
    logic [31:0]             bc_inc;
    logic                    limit_hit;
    logic [PAD_W-1:0]        unused_bits;

    assign s_axis_signal.tready = 1'b1;
    assign unused_bits = {s_axis_signal.tdata[AXIS_SIGNAL_TDATA_WIDTH-1:LANE_W+SIG_W],
                          s_axis_signal.tdata[LANE_W-1:SIG_W]};

    assign sum0 = acc0 + sext(s_axis_signal.tdata[SIG_W-1:0]);
    assign sum1 = acc1 + sext(s_axis_signal.tdata[LANE_W+SIG_W-1:LANE_W]);

    assign win_last_idx = CNT_W'((32'd1 << k_r) - 32'd1);
    assign xfer         = out_valid & m_axis_s01.tready;
    assign bc_inc       = block_count + 32'd1;
    // The transfer that brings the count to the programmed limit ends the run.
    assign limit_hit    = xfer && (num_r != 32'd0) && (bc_inc == num_r);

    assign m_axis_s01.tdata  = out_data;
    assign m_axis_s01.tvalid = out_valid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            k_r         <= '0;
            num_r       <= '0;
            acc0        <= '0;
            acc1        <= '0;
            cnt         <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            block_count <= '0;
        end else begin
            if (xfer) block_count <= bc_inc;

            case (state)
                IDLE: begin
                    if (cfg_start && !cfg_stop) begin
                        k_r         <= clamp_k(cfg_log2_dec);
                        num_r       <= cfg_num_blocks;
                        block_count <= '0;
                        overrun     <= 1'b0;
                        acc0        <= '0;
                        acc1        <= '0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        state       <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (xfer) out_valid <= 1'b0;
                    if (cfg_stop || limit_hit) begin
                        // Partial window (and any window completing now) is dropped.
                        acc0  <= '0;
                        acc1  <= '0;
                        cnt   <= '0;
                        busy  <= out_valid && !xfer;
                        state <= DRAIN;
                    end else if (s_axis_signal.tvalid) begin
                        if (cnt == win_last_idx) begin
                            acc0 <= '0;
                            acc1 <= '0;
                            cnt  <= '0;
                            // Loading is allowed when the register frees up this cycle.
                            if (!out_valid || xfer) begin
                                out_data  <= {scale(sum1, k_r), scale(sum0, k_r)};
                                out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            acc0 <= sum0;
                            acc1 <= sum1;
                            cnt  <= cnt + CNT_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (!out_valid || xfer) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_decimator_ctrl.sv
// Self-checking bench for axis_decimator_ctrl: directed scenarios plus
// randomized runs against a behavioural model; results are pushed into a
// scoreboard queue and a separate monitor pops them on every handshake.
module tb_axis_decimator_ctrl;
    logic        clk;
    logic        aresetn;
    logic [3:0]  cfg_log2_dec;
    logic [31:0] cfg_num_blocks;
    logic        cfg_start;
    logic        cfg_stop;
    logic        busy;
    logic        overrun;
    logic [31:0] block_count;

    axis_decimator_ctrl_if #(.TDATA_W(32)) s_if ();
    axis_decimator_ctrl_if #(.TDATA_W(32)) m_if ();

    axis_decimator_ctrl dut (
        .aclk          (clk),
        .aresetn       (aresetn),
        .s_axis_signal (s_if),
        .cfg_log2_dec  (cfg_log2_dec),
        .cfg_num_blocks(cfg_num_blocks),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .m_axis_s01    (m_if),
        .busy          (busy),
        .overrun       (overrun),
        .block_count   (block_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    logic [31:0] last_tdata = '0;

    // Behavioural model state
    logic [31:0] expq[$];
    bit          m_acq  = 0;
    bit          m_pend = 0;
    bit          m_ovr  = 0;
    int          m_k    = 0;
    logic [31:0] m_num  = '0;
    logic [31:0] m_bc   = '0;
    int          m_s0   = 0;
    int          m_s1   = 0;
    int          m_n    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane_val(input logic [13:0] l);
        int v;
        v = int'(l);
        if (v >= 8192) v -= 16384;
        return v;
    endfunction

    // Floor division by a power of two, from plain integer arithmetic.
    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d) != 0 && s < 0) q -= 1;
        return q;
    endfunction

    function automatic logic [31:0] pk(input int ch0, input int ch1);
        logic [31:0] w;
        logic [31:0] a;
        logic [31:0] b;
        a = ch0;
        b = ch1;
        w = $urandom;                 // junk in ignored bits
        w[13:0]  = a[13:0];
        w[29:16] = b[13:0];
        return w;
    endfunction

    // Predicts what the upcoming clock edge does, from current inputs.
    task automatic model_step();
        bit acq0;
        bit pend0;
        bit xfer;
        int d;
        logic [31:0] res;
        acq0  = m_acq;
        pend0 = m_pend;
        xfer  = pend0 && (m_if.tready === 1'b1);
        if (xfer) begin
            m_bc++;
            m_pend = 0;
        end
        if (acq0) begin
            if (cfg_stop || (xfer && m_num != 0 && m_bc == m_num)) begin
                m_acq = 0;
                m_s0 = 0; m_s1 = 0; m_n = 0;
            end else if (s_if.tvalid) begin
                m_s0 += lane_val(s_if.tdata[13:0]);
                m_s1 += lane_val(s_if.tdata[29:16]);
                m_n++;
                d = 1 << m_k;
                if (m_n == d) begin
                    res[31:16] = 16'(floor_div(m_s1, d));
                    res[15:0]  = 16'(floor_div(m_s0, d));
                    if (m_pend) m_ovr = 1;
                    else begin
                        expq.push_back(res);
                        m_pend = 1;
                    end
                    m_s0 = 0; m_s1 = 0; m_n = 0;
                end
            end
        end else if (!pend0 && cfg_start && !cfg_stop) begin
            m_acq = 1;
            m_k   = (cfg_log2_dec > 4'd8) ? 8 : int'(cfg_log2_dec);
            m_num = cfg_num_blocks;
            m_bc  = '0;
            m_ovr = 0;
            m_s0 = 0; m_s1 = 0; m_n = 0;
        end
    endtask

    // One clock cycle: check the aligned state, drive inputs, predict, advance.
    task automatic cyc(input bit v, input logic [31:0] d, input bit rdy,
                       input bit st, input bit sp);
        chk("tvalid", {31'd0, m_if.tvalid}, {31'd0, m_pend});
        chk("busy", {31'd0, busy}, {31'd0, (m_acq || m_pend)});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("block_count", block_count, m_bc);
        if (m_pend && expq.size() > 0) chk("tdata_held", m_if.tdata, expq[0]);
        s_if.tvalid = v;
        s_if.tdata  = d;
        m_if.tready = rdy;
        cfg_start   = st;
        cfg_stop    = sp;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 1, 0, 0);
    endtask

    task automatic start(input int k, input int num);
        cfg_log2_dec   = 4'(k);
        cfg_num_blocks = 32'(num);
        cyc(0, '0, 1, 1, 0);
    endtask

    task automatic finish_run();
        int n;
        n = 0;
        cyc(0, '0, 1, 0, 1);
        while (busy && n < 50) begin
            cyc(0, '0, 1, 0, 0);
            n++;
        end
        chk("drain_timeout", {31'd0, busy}, 32'd0);
        idle(2);
    endtask

    // Monitor: pops the scoreboard on every observed handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (aresetn && m_if.tvalid && m_if.tready) begin
                n_xfer++;
                last_tdata = m_if.tdata;
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got %h expected no transfer", m_if.tdata);
                end else begin
                    chk("xfer_data", m_if.tdata, expq.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int num;
        aresetn = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        m_if.tready = 1'b1;
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        cfg_log2_dec = '0;
        cfg_num_blocks = '0;
        #22;
        chk("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("rst_tdata", m_if.tdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_block_count", block_count, 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // 1: k=2, constant ch0=100 ch1=-50
        start(2, 0);
        for (int i = 0; i < 40; i++) cyc(($urandom % 4) != 0, pk(100, -50), 1, 0, 0);
        chk("s1_result", last_tdata, 32'hFFCE0064);
        finish_run();

        // 2: k=0 pass-through with one cycle latency
        start(0, 0);
        cyc(1, pk(32'h2000, 32'h1FFF), 1, 0, 0);
        chk("s2_latency_valid", {31'd0, m_if.tvalid}, 32'd1);
        chk("s2_data", m_if.tdata, 32'h1FFFE000);
        for (int i = 0; i < 6; i++) cyc(1, pk(32'h2000, 32'h1FFF), 1, 0, 0);
        finish_run();

        // 3: floor rounding of a negative average
        start(1, 0);
        cyc(1, pk(-3, 0), 1, 0, 0);
        cyc(1, pk(-2, 0), 1, 0, 0);
        chk("s3_floor", m_if.tdata, 32'h0000FFFD);
        finish_run();

        // 4: block limit of 3
        start(1, 3);
        base = n_xfer;
        for (int i = 0; i < 20; i++) cyc(1, pk($urandom, $urandom), 1, 0, 0);
        chk("s4_block_count", block_count, 32'd3);
        chk("s4_busy", {31'd0, busy}, 32'd0);
        chk("s4_xfers", 32'(n_xfer - base), 32'd3);
        chk("s4_no_more_valid", {31'd0, m_if.tvalid}, 32'd0);
        idle(2);

        // 5: backpressure across two windows -> overrun
        start(1, 0);
        cyc(1, pk(10, 0), 0, 0, 0);
        cyc(1, pk(20, 0), 0, 0, 0);
        cyc(1, pk(100, 0), 0, 0, 0);
        cyc(1, pk(100, 0), 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        chk("s5_overrun", {31'd0, overrun}, 32'd1);
        chk("s5_held_valid", {31'd0, m_if.tvalid}, 32'd1);
        chk("s5_held_data", m_if.tdata, 32'h0000000F);
        base = n_xfer;
        cyc(0, '0, 1, 0, 0);
        chk("s5_one_xfer", 32'(n_xfer - base), 32'd1);
        chk("s5_block_count", block_count, 32'd1);
        cyc(0, '0, 1, 0, 1);
        idle(2);
        start(1, 0);
        chk("s5_overrun_cleared", {31'd0, overrun}, 32'd0);
        finish_run();

        // 6: stop mid-window with a pending result
        start(2, 0);
        for (int i = 0; i < 6; i++) cyc(1, pk(i * 7, -i), 0, 0, 0);
        cyc(0, '0, 0, 0, 1);
        chk("s6_busy_pending", {31'd0, busy}, 32'd1);
        chk("s6_valid_pending", {31'd0, m_if.tvalid}, 32'd1);
        cyc(0, '0, 1, 0, 0);
        chk("s6_busy_done", {31'd0, busy}, 32'd0);
        chk("s6_block_count", block_count, 32'd1);
        idle(3);
        chk("s6_no_partial", {31'd0, m_if.tvalid}, 32'd0);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            k = (($urandom % 8) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 4));
            num = int'($urandom_range(0, 4));
            start(k, num);
            for (int i = 0; i < ((k > 4) ? 600 : 150); i++)
                cyc(($urandom % 4) != 0, pk($urandom, $urandom), ($urandom % 3) != 0,
                    m_acq && (($urandom % 16) == 0), ($urandom % 200) == 0);
            finish_run();
        end

        // Asynchronous reset in the middle of a run with a pending result
        start(1, 0);
        for (int i = 0; i < 6; i++) cyc(1, pk($urandom, $urandom), 0, 0, 0);
        aresetn = 1'b0;
        #2;
        chk("arst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("arst_tdata", m_if.tdata, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_overrun", {31'd0, overrun}, 32'd0);
        chk("arst_block_count", block_count, 32'd0);
        expq.delete();
        m_acq = 0; m_pend = 0; m_ovr = 0; m_bc = '0;
        m_s0 = 0; m_s1 = 0; m_n = 0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        start(0, 2);
        for (int i = 0; i < 8; i++) cyc(1, pk($urandom, $urandom), 1, 0, 0);
        chk("post_rst_block_count", block_count, 32'd2);
        finish_run();

        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
